i2c_target_regfile: RTL and testbench

- I2C target (slave) register file that sits on the SCL/SDA lines driven by the simple I2C master peripheral.
- Responds at a 7-bit address and holds NUM_REGS 8-bit registers behind a register-pointer byte, with auto-increment on both writes and reads.
- Used in SoC simulation and on FPGA as the on-board device the master firmware talks to.
- Also exposes a local read port and a write-event strobe so the bench and SoC logic can observe contents.

---
 rtl/i2c_target_pkg.sv | 20 ++
 rtl/i2c_line_monitor.sv | 47 ++++
 rtl/i2c_target_regfile.sv | 178 +++++++++++++++++
 tb/tb_i2c_target_regfile.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the I2C target register file.
package i2c_target_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK
  } state_t;

  localparam logic ACK_BIT    = 1'b0;
  localparam logic NACK_BIT   = 1'b1;
  localparam int   SYNC_DEPTH = 2;

endpackage

// File: rtl/i2c_line_monitor.sv
// Synchronises SCL/SDA into clk and flags SCL edges plus START/STOP conditions,
// registered so every event appears three clocks after the pin change.
module i2c_line_monitor
  import i2c_target_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda
);

  logic [SYNC_DEPTH:0] scl_pipe;
  logic [SYNC_DEPTH:0] sda_pipe;
  logic scl_s, scl_q, sda_s, sda_q;

  assign scl_s = scl_pipe[SYNC_DEPTH-1];
  assign scl_q = scl_pipe[SYNC_DEPTH];
  assign sda_s = sda_pipe[SYNC_DEPTH-1];
  assign sda_q = sda_pipe[SYNC_DEPTH];

  // Pipes reset to the idle-bus level so leaving reset never fakes an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_pipe  <= '1;
      sda_pipe  <= '1;
      scl_rise  <= 1'b0;
      scl_fall  <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
      sda       <= 1'b1;
    end else begin
      scl_pipe  <= {scl_pipe[SYNC_DEPTH-1:0], scl_i};
      sda_pipe  <= {sda_pipe[SYNC_DEPTH-1:0], sda_i};
      scl_rise  <= scl_s & ~scl_q;
      scl_fall  <= ~scl_s & scl_q;
      start_det <= scl_s & scl_q & ~sda_s & sda_q;
      stop_det  <= scl_s & scl_q & sda_s & ~sda_q;
      sda       <= sda_s;
    end
  end

endmodule

// File: rtl/i2c_target_regfile.sv
// I2C target holding NUM_REGS byte registers behind an auto-incrementing
// register pointer, with a local read port and a write-event strobe.
module i2c_target_regfile
  import i2c_target_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDRESS = 7'h50,
  parameter int         NUM_REGS       = 16,
  localparam int        PTR_W          = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             sda_oe,
  input  logic [PTR_W-1:0] loc_addr,
  output logic [7:0]       loc_rdata,
  output logic             wr_evt,
  output logic [PTR_W-1:0] wr_evt_addr,
  output logic [7:0]       wr_evt_data,
  output logic             busy
);

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_line_monitor u_line_monitor (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda       (sda_s)
  );

  state_t           state, state_d;
  logic [7:0]       shift, shift_d;
  logic [3:0]       cnt, cnt_d;
  logic [PTR_W-1:0] ptr, ptr_d;
  logic             rw, rw_d, mack, mack_d, oe_d, busy_d, wr_en;
  logic [7:0]       regs [NUM_REGS];
  logic [7:0]       cur_reg;

  assign cur_reg = regs[ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      shift       <= '0;
      cnt         <= '0;
      ptr         <= '0;
      rw          <= 1'b0;
      mack        <= NACK_BIT;
      sda_oe      <= 1'b0;
      busy        <= 1'b0;
      wr_evt      <= 1'b0;
      wr_evt_addr <= '0;
      wr_evt_data <= '0;
      loc_rdata   <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      state     <= state_d;
      shift     <= shift_d;
      cnt       <= cnt_d;
      ptr       <= ptr_d;
      rw        <= rw_d;
      mack      <= mack_d;
      sda_oe    <= oe_d;
      busy      <= busy_d;
      wr_evt    <= wr_en;
      // Local read sees the pre-write value when it collides with an I2C write.
      loc_rdata <= regs[loc_addr];
      if (wr_en) begin
        regs[ptr]   <= shift;
        wr_evt_addr <= ptr;
        wr_evt_data <= shift;
      end
    end
  end

  // Bits are captured on SCL rise; every SDA drive change happens on SCL fall.
  always_comb begin
    state_d = state;
    shift_d = shift;
    cnt_d   = cnt;
    ptr_d   = ptr;
    rw_d    = rw;
    mack_d  = mack;
    oe_d    = sda_oe;
    busy_d  = busy;
    wr_en   = 1'b0;
    if (stop_det) begin
      state_d = ST_IDLE;
      oe_d    = 1'b0;
    end else if (start_det) begin
      state_d = ST_ADDR;
      cnt_d   = '0;
      oe_d    = 1'b0;
    end else if (scl_rise) begin
      case (state)
        ST_ADDR, ST_PTR, ST_WDATA: begin
          shift_d = {shift[6:0], sda_s};
          cnt_d   = cnt + 4'd1;
        end
        ST_RDATA:     cnt_d  = cnt + 4'd1;
        ST_RDATA_ACK: mack_d = sda_s;
        default: ;
      endcase
    end else if (scl_fall) begin
      case (state)
        ST_ADDR: if (cnt == 4'd8) begin
          if (shift[7:1] == TARGET_ADDRESS) begin
            state_d = ST_ADDR_ACK;
            rw_d    = shift[0];
            oe_d    = ~ACK_BIT;
            busy_d  = 1'b1;
          end else begin
            state_d = ST_IDLE;
            oe_d    = 1'b0;
          end
        end
        ST_ADDR_ACK: begin
          cnt_d = '0;
          if (rw) begin
            state_d = ST_RDATA;
            shift_d = cur_reg;
            ptr_d   = ptr + PTR_W'(1);
            oe_d    = ~cur_reg[7];
          end else begin
            state_d = ST_PTR;
            oe_d    = 1'b0;
          end
        end
        ST_PTR: if (cnt == 4'd8) begin
          state_d = ST_PTR_ACK;
          ptr_d   = shift[PTR_W-1:0];
          oe_d    = ~ACK_BIT;
        end
        ST_PTR_ACK, ST_WDATA_ACK: begin
          state_d = ST_WDATA;
          cnt_d   = '0;
          oe_d    = 1'b0;
        end
        ST_WDATA: if (cnt == 4'd8) begin
          state_d = ST_WDATA_ACK;
          wr_en   = 1'b1;
          ptr_d   = ptr + PTR_W'(1);
          oe_d    = ~ACK_BIT;
        end
        ST_RDATA: begin
          if (cnt == 4'd8) begin
            state_d = ST_RDATA_ACK;
            oe_d    = 1'b0;
          end else begin
            shift_d = {shift[6:0], 1'b0};
            oe_d    = ~shift[6];
          end
        end
        ST_RDATA_ACK: begin
          if (mack == NACK_BIT) begin
            state_d = ST_IDLE;
            oe_d    = 1'b0;
          end else begin
            state_d = ST_RDATA;
            cnt_d   = '0;
            shift_d = cur_reg;
            ptr_d   = ptr + PTR_W'(1);
            oe_d    = ~cur_reg[7];
          end
        end
        default: ;
      endcase
    end
    if (state_d == ST_IDLE) busy_d = 1'b0;
  end

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Bench for i2c_target_regfile: an open-drain I2C master model issues directed
// transactions; expected ACK bits, read bytes and write events go through queues.
module tb_i2c_target_regfile;

  localparam int  PTR_W = 4;
  localparam time T     = 100ns;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             scl = 1'b1;
  logic             m_sda = 1'b1;
  logic [PTR_W-1:0] loc_addr = '0;
  logic             sda_oe, wr_evt, busy;
  logic [7:0]       loc_rdata, wr_evt_data;
  logic [PTR_W-1:0] wr_evt_addr;
  logic             sda_line;

  assign sda_line = m_sda & ~sda_oe;

  always #5ns clk = ~clk;

  i2c_target_regfile #(.TARGET_ADDRESS(7'h50), .NUM_REGS(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .scl_i       (scl),
    .sda_i       (sda_line),
    .sda_oe      (sda_oe),
    .loc_addr    (loc_addr),
    .loc_rdata   (loc_rdata),
    .wr_evt      (wr_evt),
    .wr_evt_addr (wr_evt_addr),
    .wr_evt_data (wr_evt_data),
    .busy        (busy)
  );

  typedef struct {
    string      name;
    logic [7:0] val;
  } rx_t;

  rx_t         exp_rx[$];
  logic [11:0] exp_wr[$];
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data  = '0;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: compares each observed bus response and write event.
  always @(negedge clk) begin : monitor
    rx_t e;
    if (rx_valid) begin
      if (exp_rx.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL rx_unexpected: got %0h, expected nothing", rx_data);
      end else begin
        e = exp_rx.pop_front();
        check(e.name, {8'h0, rx_data}, {8'h0, e.val});
      end
    end
    if (wr_evt) begin
      if (exp_wr.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL wr_evt_unexpected: got %0h/%0h, expected no event", wr_evt_addr, wr_evt_data);
      end else begin
        check("wr_evt", {4'h0, wr_evt_addr, wr_evt_data}, {4'h0, exp_wr.pop_front()});
      end
    end
  end

  task automatic post_rx(input logic [7:0] v);
    @(posedge clk);
    #1ns;
    rx_data  = v;
    rx_valid = 1'b1;
    @(posedge clk);
    #1ns;
    rx_valid = 1'b0;
  endtask

  task automatic expect_rx(input string name, input logic [7:0] v);
    rx_t e;
    e.name = name;
    e.val  = v;
    exp_rx.push_back(e);
  endtask

  task automatic send_bit(input logic b);
    m_sda = b;
    #T scl = 1'b1;
    #(2*T) scl = 1'b0;
    #T;
  endtask

  task automatic recv_bit(output logic b);
    m_sda = 1'b1;
    #T scl = 1'b1;
    #T b = sda_line;
    #T scl = 1'b0;
    #T;
  endtask

  task automatic i2c_start();
    m_sda = 1'b1;
    #T scl = 1'b1;
    #T m_sda = 1'b0;
    #T scl = 1'b0;
    #T;
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0;
    #T scl = 1'b1;
    #T m_sda = 1'b1;
    #(2*T);
  endtask

  task automatic wr_byte(input string name, input logic [7:0] v, input logic exp_ack);
    logic a;
    expect_rx(name, {7'h0, exp_ack});
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
    recv_bit(a);
    post_rx({7'h0, a});
  endtask

  task automatic rd_byte(input string name, input logic [7:0] exp, input logic ack);
    logic [7:0] d;
    logic       b;
    expect_rx(name, exp);
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(ack);
    post_rx(d);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1ns;
  endtask

  task automatic loc_chk(input int a, input logic [7:0] e);
    @(posedge clk);
    #1ns;
    loc_addr = PTR_W'(a);
    @(posedge clk);
    #1ns;
    check($sformatf("reg%0d", a), {8'h0, loc_rdata}, {8'h0, e});
  endtask

  initial begin : watchdog
    #3ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "bench timed out");
  end

  initial begin : stimulus
    wait_clk(5);
    check("rst_sda_oe", {15'h0, sda_oe}, 16'h0);
    check("rst_busy", {15'h0, busy}, 16'h0);
    check("rst_wr_evt", {15'h0, wr_evt}, 16'h0);
    check("rst_loc_rdata", {8'h0, loc_rdata}, 16'h0);
    rst = 1'b0;
    wait_clk(5);

    // Write burst starting at register 3.
    exp_wr.push_back({4'h3, 8'hA5});
    exp_wr.push_back({4'h4, 8'h5A});
    i2c_start();
    wr_byte("wb_addr_ack", 8'hA0, 1'b0);
    check("wb_busy", {15'h0, busy}, 16'h1);
    wr_byte("wb_ptr_ack", 8'h03, 1'b0);
    wr_byte("wb_d0_ack", 8'hA5, 1'b0);
    wr_byte("wb_d1_ack", 8'h5A, 1'b0);
    i2c_stop();
    wait_clk(4);
    check("wb_busy_after_stop", {15'h0, busy}, 16'h0);
    loc_chk(3, 8'hA5);
    loc_chk(4, 8'h5A);
    loc_chk(2, 8'h00);

    // Combined read with repeated START.
    i2c_start();
    wr_byte("cr_addr_ack", 8'hA0, 1'b0);
    wr_byte("cr_ptr_ack", 8'h03, 1'b0);
    i2c_start();
    wr_byte("cr_raddr_ack", 8'hA1, 1'b0);
    rd_byte("cr_byte0", 8'hA5, 1'b0);
    rd_byte("cr_byte1", 8'h5A, 1'b1);
    check("cr_oe_after_nack", {15'h0, sda_oe}, 16'h0);
    check("cr_busy_after_nack", {15'h0, busy}, 16'h0);
    i2c_stop();

    // Address mismatch: target must stay silent.
    i2c_start();
    wr_byte("mm_addr_nack", 8'hA2, 1'b1);
    check("mm_busy", {15'h0, busy}, 16'h0);
    wr_byte("mm_b1_nack", 8'h00, 1'b1);
    wr_byte("mm_b2_nack", 8'hFF, 1'b1);
    i2c_stop();
    loc_chk(0, 8'h00);
    loc_chk(3, 8'hA5);

    // Pointer wrap and ignored upper pointer bits.
    exp_wr.push_back({4'hF, 8'h11});
    exp_wr.push_back({4'h0, 8'h22});
    i2c_start();
    wr_byte("wr_addr_ack", 8'hA0, 1'b0);
    wr_byte("wr_ptr_ack", 8'h0F, 1'b0);
    wr_byte("wr_d0_ack", 8'h11, 1'b0);
    wr_byte("wr_d1_ack", 8'h22, 1'b0);
    i2c_stop();
    exp_wr.push_back({4'h3, 8'h77});
    i2c_start();
    wr_byte("wr13_addr_ack", 8'hA0, 1'b0);
    wr_byte("wr13_ptr_ack", 8'h13, 1'b0);
    wr_byte("wr13_d_ack", 8'h77, 1'b0);
    i2c_stop();
    loc_chk(15, 8'h11);
    loc_chk(0, 8'h22);
    loc_chk(3, 8'h77);

    // STOP in the middle of a data byte.
    i2c_start();
    wr_byte("ab_addr_ack", 8'hA0, 1'b0);
    wr_byte("ab_ptr_ack", 8'h05, 1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    i2c_stop();
    wait_clk(4);
    check("ab_sda_oe", {15'h0, sda_oe}, 16'h0);
    check("ab_busy", {15'h0, busy}, 16'h0);
    loc_chk(5, 8'h00);
    exp_wr.push_back({4'h6, 8'h99});
    i2c_start();
    wr_byte("ab2_addr_ack", 8'hA0, 1'b0);
    wr_byte("ab2_ptr_ack", 8'h06, 1'b0);
    wr_byte("ab2_d_ack", 8'h99, 1'b0);
    i2c_stop();
    loc_chk(6, 8'h99);

    // Reset while the target drives the first read bit (reg7 = 0 -> SDA low).
    i2c_start();
    wr_byte("rr_addr_ack", 8'hA1, 1'b0);
    check("rr_oe_driving", {15'h0, sda_oe}, 16'h1);
    @(posedge clk);
    #1ns;
    rst = 1'b1;
    @(posedge clk);
    #1ns;
    check("rr_oe_after_rst", {15'h0, sda_oe}, 16'h0);
    m_sda = 1'b1;
    scl   = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(5);
    for (int a = 0; a < 16; a++) loc_chk(a, 8'h00);

    wait_clk(10);
    check("rx_queue_drained", 16'(exp_rx.size()), 16'h0);
    check("wr_queue_drained", 16'(exp_wr.size()), 16'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
